// File: rtl/draw_circle_multi.sv
// draw_circle_multi: overlays up to N_OBJ circles (discs or rings) on a video
// stream through a fixed 3-stage pipeline. Circle positions and enables are
// shadowed on each vblank rise, so a frame never mixes old and new positions.
module draw_circle_multi #(
    parameter int                  N_OBJ  = 2,
    parameter int                  RADIUS = 20,
    parameter logic [N_OBJ*12-1:0] COLORS = {12'h0ff, 12'hfff},
    parameter int                  RING_W = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [11:0]           hcount_in,
    input  logic [11:0]           vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblnk_in,
    input  logic                  vblnk_in,
    input  logic [11:0]           rgb_in,
    input  logic [N_OBJ*12-1:0]   xpos_in,
    input  logic [N_OBJ*12-1:0]   ypos_in,
    input  logic [N_OBJ-1:0]      obj_en_in,
    output logic [11:0]           hcount_out,
    output logic [11:0]           vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [11:0]           rgb_out,
    output logic [N_OBJ*12-1:0]   xpos_out,
    output logic [N_OBJ*12-1:0]   ypos_out,
    output logic                  frame_latched_out
);

    // Inner radius is zero for filled discs and for rings at least as thick as the circle.
    localparam int          R_IN     = (RING_W > 0 && RING_W < RADIUS) ? (RADIUS - RING_W) : 0;
    localparam logic [26:0] R_SQ_OUT = 27'(RADIUS * RADIUS);
    localparam logic [26:0] R_SQ_IN  = 27'(R_IN * R_IN);
    localparam int          BW       = 24 * N_OBJ + 41;

    logic                         r_vblnkPrev;
    logic                         r_armed;
    logic                         w_latch;
    logic [N_OBJ-1:0][11:0]       r_xs;
    logic [N_OBJ-1:0][11:0]       r_ys;
    logic [N_OBJ-1:0]             r_en;

    logic [BW-1:0]                w_busIn;
    logic [BW-1:0]                r_bus1;
    logic [BW-1:0]                r_bus2;

    logic [N_OBJ-1:0][12:0]       r_dx;
    logic [N_OBJ-1:0][12:0]       r_dy;
    logic [N_OBJ-1:0]             r_en1;
    logic [N_OBJ-1:0][11:0]       w_ax;
    logic [N_OBJ-1:0][11:0]       w_ay;
    logic [N_OBJ-1:0][26:0]       r_d2;
    logic [N_OBJ-1:0]             r_en2;
    logic [N_OBJ-1:0]             w_lowOk;
    logic [N_OBJ-1:0]             w_hit;
    logic [11:0]                  w_rgbNext;

    logic [11:0]                  w_h2;
    logic [11:0]                  w_v2;
    logic                         w_hs2;
    logic                         w_vs2;
    logic                         w_hb2;
    logic                         w_vb2;
    logic [11:0]                  w_rgb2;
    logic [N_OBJ*12-1:0]          w_xpos2;
    logic [N_OBJ*12-1:0]          w_ypos2;
    logic                         w_lat2;

    assign w_latch = vblnk_in & ~r_vblnkPrev;
    assign w_busIn = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
                      rgb_in, xpos_in, ypos_in, w_latch};
    assign {w_h2, w_v2, w_hs2, w_vs2, w_hb2, w_vb2, w_rgb2, w_xpos2, w_ypos2, w_lat2} = r_bus2;

    // Shadow registers: take a consistent snapshot of positions and enables on each vblank rise.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_vblnkPrev <= 1'b0;
            r_armed     <= 1'b0;
            r_xs        <= '0;
            r_ys        <= '0;
            r_en        <= '0;
        end else begin
            r_vblnkPrev <= vblnk_in;
            if (w_latch) begin
                r_armed <= 1'b1;
                r_xs    <= xpos_in;
                r_ys    <= ypos_in;
                r_en    <= obj_en_in;
            end
        end
    end

    // Stage 1: 13-bit two's-complement offsets of the pixel from every shadow centre.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_bus1 <= '0;
            r_en1  <= '0;
            r_dx   <= '0;
            r_dy   <= '0;
        end else begin
            r_bus1 <= w_busIn;
            r_en1  <= r_armed ? r_en : '0;
            for (int k = 0; k < N_OBJ; k++) begin
                r_dx[k] <= {1'b0, hcount_in} - {1'b0, r_xs[k]};
                r_dy[k] <= {1'b0, vcount_in} - {1'b0, r_ys[k]};
            end
        end
    end

    // Magnitudes of the offsets, so squaring stays in unsigned arithmetic without wrap.
    always_comb begin
        w_ax = '0;
        w_ay = '0;
        for (int k = 0; k < N_OBJ; k++) begin
            w_ax[k] = r_dx[k][12] ? 12'(-r_dx[k]) : r_dx[k][11:0];
            w_ay[k] = r_dy[k][12] ? 12'(-r_dy[k]) : r_dy[k][11:0];
        end
    end

    // Stage 2: full-precision squared distance per object.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_bus2 <= '0;
            r_en2  <= '0;
            r_d2   <= '0;
        end else begin
            r_bus2 <= r_bus1;
            r_en2  <= r_en1;
            for (int k = 0; k < N_OBJ; k++) begin
                r_d2[k] <= 27'(w_ax[k]) * 27'(w_ax[k]) + 27'(w_ay[k]) * 27'(w_ay[k]);
            end
        end
    end

    // Lower bound of the ring band only exists when an inner radius is configured.
    generate
        if (R_IN > 0) begin : g_ring
            always_comb begin
                w_lowOk = '0;
                for (int k = 0; k < N_OBJ; k++) begin
                    w_lowOk[k] = (r_d2[k] >= R_SQ_IN);
                end
            end
        end else begin : g_disc
            assign w_lowOk = '1;
        end
    endgenerate

    // Stage 3 decision: hit test, lowest index wins, blanking forces black.
    always_comb begin
        w_hit     = '0;
        w_rgbNext = w_rgb2;
        for (int k = 0; k < N_OBJ; k++) begin
            w_hit[k] = r_en2[k] && w_lowOk[k] && (r_d2[k] <= R_SQ_OUT);
        end
        for (int k = N_OBJ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_rgbNext = COLORS[12*k +: 12];
            end
        end
        if (w_hb2 || w_vb2) begin
            w_rgbNext = 12'h000;
        end
    end

    // Stage 3 register: drive all outputs aligned with the resolved pixel colour.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            hcount_out        <= '0;
            vcount_out        <= '0;
            hsync_out         <= 1'b0;
            vsync_out         <= 1'b0;
            hblnk_out         <= 1'b0;
            vblnk_out         <= 1'b0;
            rgb_out           <= '0;
            xpos_out          <= '0;
            ypos_out          <= '0;
            frame_latched_out <= 1'b0;
        end else begin
            hcount_out        <= w_h2;
            vcount_out        <= w_v2;
            hsync_out         <= w_hs2;
            vsync_out         <= w_vs2;
            hblnk_out         <= w_hb2;
            vblnk_out         <= w_vb2;
            rgb_out           <= w_rgbNext;
            xpos_out          <= w_xpos2;
            ypos_out          <= w_ypos2;
            frame_latched_out <= w_lat2;
        end
    end

endmodule

// File: tb/tb_draw_circle_multi.sv
// Testbench for draw_circle_multi: a disc instance and a ring instance share
// one randomized video stream and are compared every cycle against a
// pixel-level model, with directed pixels pinning known geometry.
module tb_draw_circle_multi;

    localparam int N      = 2;
    localparam int RADIUS = 20;
    localparam int IN_SQ_RING = (RADIUS - 5) * (RADIUS - 5);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n = 1'b0;
    logic [11:0]     hIn = '0, vIn = '0, rgbIn = '0;
    logic            hsIn = 1'b0, vsIn = 1'b0, hbIn = 1'b0, vbIn = 1'b0;
    logic [N*12-1:0] xposIn = '0, yposIn = '0;
    logic [N-1:0]    enIn = '0;

    logic [11:0]     o0H, o0V, o0Rgb, o1H, o1V, o1Rgb;
    logic            o0Hs, o0Vs, o0Hb, o0Vb, o0Fl, o1Hs, o1Vs, o1Hb, o1Vb, o1Fl;
    logic [N*12-1:0] o0X, o0Y, o1X, o1Y;

    draw_circle_multi #(.N_OBJ(N), .RADIUS(RADIUS), .RING_W(0)) dutDisc (
        .clk_in(clk), .rst_n(rst_n), .hcount_in(hIn), .vcount_in(vIn),
        .hsync_in(hsIn), .vsync_in(vsIn), .hblnk_in(hbIn), .vblnk_in(vbIn),
        .rgb_in(rgbIn), .xpos_in(xposIn), .ypos_in(yposIn), .obj_en_in(enIn),
        .hcount_out(o0H), .vcount_out(o0V), .hsync_out(o0Hs), .vsync_out(o0Vs),
        .hblnk_out(o0Hb), .vblnk_out(o0Vb), .rgb_out(o0Rgb), .xpos_out(o0X),
        .ypos_out(o0Y), .frame_latched_out(o0Fl));

    draw_circle_multi #(.N_OBJ(N), .RADIUS(RADIUS), .RING_W(5)) dutRing (
        .clk_in(clk), .rst_n(rst_n), .hcount_in(hIn), .vcount_in(vIn),
        .hsync_in(hsIn), .vsync_in(vsIn), .hblnk_in(hbIn), .vblnk_in(vbIn),
        .rgb_in(rgbIn), .xpos_in(xposIn), .ypos_in(yposIn), .obj_en_in(enIn),
        .hcount_out(o1H), .vcount_out(o1V), .hsync_out(o1Hs), .vsync_out(o1Vs),
        .hblnk_out(o1Hb), .vblnk_out(o1Vb), .rgb_out(o1Rgb), .xpos_out(o1X),
        .ypos_out(o1Y), .frame_latched_out(o1Fl));

    typedef struct packed {
        logic [11:0]     h;
        logic [11:0]     v;
        logic            hs;
        logic            vs;
        logic            hb;
        logic            vb;
        logic [11:0]     rgbDisc;
        logic [11:0]     rgbRing;
        logic [N*12-1:0] xp;
        logic [N*12-1:0] yp;
        logic            fl;
    } rec_t;

    rec_t            p1 = '0, p2 = '0, expOut = '0;
    logic [N*12-1:0] shX = '0, shY = '0;
    logic [N-1:0]    shEn = '0;
    logic            armed = 1'b0, prevV = 1'b0;
    int              total = 0, bad = 0;
    bit              checkEn = 1'b0;

    function automatic logic [11:0] colourOf(input int k);
        return (k == 0) ? 12'hfff : 12'h0ff;
    endfunction

    // Pixel colour from the geometric rule: inside the annulus [inner, RADIUS], lowest index first.
    function automatic logic [11:0] modelRgb(input logic [11:0] h, input logic [11:0] v,
                                             input logic [11:0] rgb, input logic hb,
                                             input logic vb, input int innerSq);
        logic [11:0] res = rgb;
        bit found = 0;
        int dx, dy, d2;
        if (armed) begin
            for (int k = 0; k < N; k++) begin
                dx = int'(h) - int'(shX[12*k +: 12]);
                dy = int'(v) - int'(shY[12*k +: 12]);
                d2 = dx * dx + dy * dy;
                if (!found && shEn[k] && d2 >= innerSq && d2 <= RADIUS * RADIUS) begin
                    res   = colourOf(k);
                    found = 1;
                end
            end
        end
        if (hb || vb) res = 12'h000;
        return res;
    endfunction

    function automatic rec_t makeRec();
        rec_t r;
        r.h = hIn;  r.v = vIn;  r.hs = hsIn; r.vs = vsIn; r.hb = hbIn; r.vb = vbIn;
        r.rgbDisc = modelRgb(hIn, vIn, rgbIn, hbIn, vbIn, 0);
        r.rgbRing = modelRgb(hIn, vIn, rgbIn, hbIn, vbIn, IN_SQ_RING);
        r.xp = xposIn; r.yp = yposIn;
        r.fl = vbIn && !prevV;
        return r;
    endfunction

    // Reference: three-deep queue of expected output records plus the frame snapshot.
    always @(posedge clk) begin
        if (!rst_n) begin
            p1 <= '0; p2 <= '0; expOut <= '0;
            shX <= '0; shY <= '0; shEn <= '0; armed <= 1'b0; prevV <= 1'b0;
        end else begin
            p1     <= makeRec();
            p2     <= p1;
            expOut <= p2;
            prevV  <= vbIn;
            if (vbIn && !prevV) begin
                shX <= xposIn; shY <= yposIn; shEn <= enIn; armed <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("disc_hcount", 64'(o0H),   64'(expOut.h));
            checkOutput("disc_vcount", 64'(o0V),   64'(expOut.v));
            checkOutput("disc_hsync",  64'(o0Hs),  64'(expOut.hs));
            checkOutput("disc_vsync",  64'(o0Vs),  64'(expOut.vs));
            checkOutput("disc_hblnk",  64'(o0Hb),  64'(expOut.hb));
            checkOutput("disc_vblnk",  64'(o0Vb),  64'(expOut.vb));
            checkOutput("disc_rgb",    64'(o0Rgb), 64'(expOut.rgbDisc));
            checkOutput("disc_xpos",   64'(o0X),   64'(expOut.xp));
            checkOutput("disc_ypos",   64'(o0Y),   64'(expOut.yp));
            checkOutput("disc_latch",  64'(o0Fl),  64'(expOut.fl));
            checkOutput("ring_hcount", 64'(o1H),   64'(expOut.h));
            checkOutput("ring_vcount", 64'(o1V),   64'(expOut.v));
            checkOutput("ring_hsync",  64'(o1Hs),  64'(expOut.hs));
            checkOutput("ring_vsync",  64'(o1Vs),  64'(expOut.vs));
            checkOutput("ring_hblnk",  64'(o1Hb),  64'(expOut.hb));
            checkOutput("ring_vblnk",  64'(o1Vb),  64'(expOut.vb));
            checkOutput("ring_rgb",    64'(o1Rgb), 64'(expOut.rgbRing));
            checkOutput("ring_xpos",   64'(o1X),   64'(expOut.xp));
            checkOutput("ring_ypos",   64'(o1Y),   64'(expOut.yp));
            checkOutput("ring_latch",  64'(o1Fl),  64'(expOut.fl));
        end
    end

    task automatic applyStimulus(input logic [11:0] h, input logic [11:0] v,
                                 input logic [11:0] rgb, input logic hb, input logic vb);
        @(negedge clk);
        hIn = h; vIn = v; rgbIn = rgb; hbIn = hb; vbIn = vb;
    endtask

    // One pixel, then two idle pixels; the result is visible at the third negedge.
    task automatic pixelCheck(input string name, input logic [11:0] h, input logic [11:0] v,
                              input logic [11:0] rgb, input logic [11:0] expDisc,
                              input logic [11:0] expRing);
        applyStimulus(h, v, rgb, 1'b0, 1'b0);
        applyStimulus(12'd2000, 12'd2000, 12'h000, 1'b0, 1'b0);
        applyStimulus(12'd2000, 12'd2000, 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({name, "_disc"},  64'(o0Rgb),          64'(expDisc));
        checkOutput({name, "_ring"},  64'(o1Rgb),          64'(expRing));
        checkOutput({name, "_model"}, 64'(expOut.rgbDisc), 64'(expDisc));
    endtask

    task automatic latchFrame(input bit checkPulse);
        applyStimulus(12'd2000, 12'd2000, 12'h555, 1'b0, 1'b1);
        applyStimulus(12'd2000, 12'd2000, 12'h555, 1'b0, 1'b1);
        applyStimulus(12'd2000, 12'd2000, 12'h555, 1'b0, 1'b0);
        @(negedge clk);
        if (checkPulse) begin
            checkOutput("latch_pulse_high", 64'(o0Fl),  64'd1);
            checkOutput("vblank_black",     64'(o0Rgb), 64'd0);
        end
        @(negedge clk);
        if (checkPulse) checkOutput("latch_pulse_low", 64'(o0Fl), 64'd0);
    endtask

    initial begin
        int k, off;
        int vbLeft = 0;
        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset_rgb",    64'(o0Rgb), 64'd0);
        checkOutput("reset_hcount", 64'(o0H),   64'd0);
        checkOutput("reset_latch",  64'(o0Fl),  64'd0);
        rst_n = 1'b1;

        xposIn = {12'd1000, 12'd100};
        yposIn = {12'd1000, 12'd100};
        enIn   = 2'b11;
        pixelCheck("prelatch", 12'd100, 12'd100, 12'h123, 12'h123, 12'h123);
        latchFrame(1);
        pixelCheck("r32_edge_in",  12'd120, 12'd100, 12'h123, 12'hfff, 12'hfff);
        pixelCheck("r32_edge_out", 12'd121, 12'd100, 12'h123, 12'h123, 12'h123);

        xposIn[11:0] = 12'd300;
        pixelCheck("r34_old_centre", 12'd120, 12'd100, 12'h123, 12'hfff, 12'hfff);
        pixelCheck("r34_new_before", 12'd300, 12'd100, 12'h123, 12'h123, 12'h123);
        latchFrame(1);
        pixelCheck("r34_new_after",  12'd300, 12'd100, 12'h123, 12'hfff, 12'h123);
        pixelCheck("r34_old_after",  12'd120, 12'd100, 12'h123, 12'h123, 12'h123);

        xposIn = {12'd200, 12'd200};
        yposIn = {12'd200, 12'd200};
        latchFrame(0);
        pixelCheck("r33_priority", 12'd200, 12'd200, 12'h123, 12'hfff, 12'h123);
        enIn = 2'b10;
        latchFrame(0);
        pixelCheck("r33_obj1", 12'd200, 12'd200, 12'h123, 12'h0ff, 12'h123);

        xposIn = {12'd1000, 12'd50};
        yposIn = {12'd1000, 12'd50};
        enIn   = 2'b01;
        latchFrame(0);
        pixelCheck("r35_centre", 12'd50, 12'd50, 12'h123, 12'hfff, 12'h123);
        pixelCheck("r35_inner",  12'd65, 12'd50, 12'h123, 12'hfff, 12'hfff);
        pixelCheck("r35_outer",  12'd70, 12'd50, 12'h123, 12'hfff, 12'hfff);
        pixelCheck("r35_beyond", 12'd71, 12'd50, 12'h123, 12'h123, 12'h123);

        xposIn = {12'd1000, 12'd5};
        yposIn = {12'd1000, 12'd5};
        latchFrame(0);
        pixelCheck("r36_origin", 12'd0,    12'd0, 12'h123, 12'hfff, 12'h123);
        pixelCheck("r36_nowrap", 12'd4095, 12'd0, 12'h123, 12'h123, 12'h123);

        applyStimulus(12'd5, 12'd5, 12'habc, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("r37_reset_rgb",    64'(o0Rgb), 64'd0);
        checkOutput("r37_reset_hcount", 64'(o0H),   64'd0);
        @(negedge clk);
        checkOutput("r37_reset_xpos",   64'(o0X),   64'd0);
        rst_n = 1'b1;
        pixelCheck("r37_not_armed", 12'd5, 12'd5, 12'h456, 12'h456, 12'h456);
        latchFrame(0);
        pixelCheck("r37_rearmed",   12'd5, 12'd5, 12'h456, 12'hfff, 12'h456);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                for (int j = 0; j < N; j++) begin
                    xposIn[12*j +: 12] = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 30))
                                                                     : 12'($urandom_range(0, 4095));
                    yposIn[12*j +: 12] = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 30))
                                                                     : 12'($urandom_range(0, 4095));
                end
                enIn = 2'($urandom_range(0, 3));
            end
            hsIn  = 1'($urandom_range(0, 1));
            vsIn  = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 499) != 0);
            k     = int'($urandom_range(0, N - 1));
            off   = int'($urandom_range(0, 50)) - 25;
            if (vbLeft > 0) vbLeft--;
            else if ($urandom_range(0, 59) == 0) vbLeft = int'($urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0)
                applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                              12'($urandom_range(0, 4095)), ($urandom_range(0, 9) == 0),
                              (vbLeft > 0));
            else
                applyStimulus(12'(int'(xposIn[12*k +: 12]) + off),
                              12'(int'(yposIn[12*k +: 12]) + int'($urandom_range(0, 50)) - 25),
                              12'($urandom_range(0, 4095)), ($urandom_range(0, 9) == 0),
                              (vbLeft > 0));
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_circle_multi.md
DRAW_CIRCLE_MULTI -- requirements
Module: draw_circle_multi

Interface
REQ-001 SHALL have parameter N_OBJ, default 2: number of circles drawn (1..8).
REQ-002 SHALL have parameter RADIUS, default 20: circle radius in pixels, common to all objects (1..255).
REQ-003 SHALL have parameter COLORS, width N_OBJ*12, default {12'h0ff, 12'hfff}: object k colour is in bits [12k+11:12k].
REQ-004 SHALL have parameter RING_W, default 0: 0 draws filled discs; a value >0 draws rings of that thickness, measured inward from RADIUS.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have ports hcount_in / vcount_in, input, 12 bits each: pixel counters.
REQ-008 SHALL have ports hsync_in, vsync_in, hblnk_in, vblnk_in, input, 1 bit each: timing signals.
REQ-009 SHALL have port rgb_in, input, 12 bits: background pixel.
REQ-010 SHALL have ports xpos_in / ypos_in, input, N_OBJ*12 bits each: circle centres, object k in bits [12k+11:12k].
REQ-011 SHALL have port obj_en_in, input, N_OBJ bits: per-object draw enable.
REQ-012 SHALL have ports hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, output, with widths matching their inputs.
REQ-013 SHALL have ports xpos_out / ypos_out, output, N_OBJ*12 bits each: xpos_in / ypos_in delayed to match the pipeline latency.
REQ-014 SHALL have port frame_latched_out, output, 1 bit: one-cycle pulse, aligned with the output stream, when new shadow positions take effect.

Function
REQ-015 SHALL delay all timing signals, counters, xpos_out / ypos_out and rgb_out by exactly 3 clk_in cycles relative to the inputs.
REQ-016 SHALL hold per-object shadow registers for xpos, ypos and enable, and SHALL use only the shadow values for drawing.
REQ-017 SHALL load all shadow registers simultaneously in the cycle after a rising edge of vblnk_in, detected against a registered copy of vblnk_in.
REQ-018 SHALL ignore changes on xpos_in, ypos_in and obj_en_in between latch events, so that no frame ever mixes positions (no tearing).
REQ-019 SHALL set an internal armed flag on the first latch after reset; while the flag is clear, rgb_out SHALL equal rgb_in delayed by 3 cycles.
REQ-020 SHALL compute, in stage 1, signed 13-bit differences dx = hcount_in - xs_k and dy = vcount_in - ys_k for each object k.
REQ-021 SHALL compute, in stage 2, d2_k = dx*dx + dy*dy as an unsigned 27-bit value with no truncation.
REQ-022 SHALL make object k a hit, in stage 3, when it is enabled and RADIUS_SQ_IN <= d2_k <= RADIUS*RADIUS.
REQ-023 SHALL define RADIUS_SQ_IN as 0 when RING_W = 0, and otherwise as (RADIUS-RING_W)^2, clamped to 0 when RING_W >= RADIUS.
REQ-024 SHALL resolve overlapping hits by priority: the lowest object index wins; with no hit, rgb_out SHALL be the delayed rgb_in.
REQ-025 SHALL force rgb_out to 12'h000 whenever the delayed hblnk or vblnk is high.
REQ-026 SHALL pulse frame_latched_out exactly 3 cycles after the latch cycle, for one cycle.
REQ-027 SHALL draw correctly for centres near screen edges and at hcount or vcount = 0: negative differences must produce no wrap artefacts.
REQ-028 SHALL, if xpos_in changes in the same cycle as the latch, capture the value present in the latch cycle.

Reset
REQ-029 SHALL, while rst_n = 0 at a clk_in edge, clear every output, every pipeline stage, every shadow register, the registered vblnk copy and the armed flag to 0.
REQ-030 SHALL, on reset asserted mid-frame, produce all-zero outputs from the next edge on, and SHALL resume drawing only after the first vblnk rising edge following release.
REQ-031 SHALL, after release, produce pass-through values on rgb_out and the timing outputs starting 3 cycles after the first post-reset input.

Verification
REQ-032 SHALL be verified with object 0 at (100,100), N_OBJ = 2, enabled and latched: pixel (120,100) -> rgb_out 12'hfff; pixel (121,100) -> rgb_in; each 3 cycles later.
REQ-033 SHALL be verified with both objects at (200,200): pixel (200,200) -> 12'hfff (object 0 priority); with obj_en_in = 2'b10 -> 12'h0ff.
REQ-034 SHALL be verified by changing xpos_in mid-frame from 100 to 300: the drawn centre stays at 100 until the next vblnk rise; frame_latched_out pulses once.
REQ-035 SHALL be verified with RING_W = 5 and centre (50,50): pixel (50,50) -> rgb_in; (65,50) -> colour; (70,50) -> colour; (71,50) -> rgb_in.
REQ-036 SHALL be verified with centre (5,5): pixel (0,0) -> colour; pixel (4095,0) -> rgb_in (no wrap).
REQ-037 SHALL be verified by asserting rst_n = 0 for 2 cycles mid-line: all outputs 0; after release, no circle is drawn before the next vblnk rising edge.
